// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequencer and two-port arbiter for the 256-byte data RAM.
// The instruction-fetch port and the load/store port share one MFA/MFC handshake
// port to the RAM. Double-word ldd/std is split into two word transactions.
// Misaligned addresses and unknown opcodes are rejected without a RAM access.
// A missing MFC is recovered by a timeout.
//
// Ports
//   clk, reset                   rising-edge clock, async active-high reset
//   if_req/if_addr               fetch request (held until if_ack)
//   if_ack/if_err/if_data        fetch completion pulse, error, fetched word
//   d_req/d_opcode/d_addr/d_wdata load/store request (held until d_ack)
//   d_ack/d_err/d_rdata          data completion pulse, error, load result
//   ram_mfa/ram_opcode/ram_addr/ram_din  registered command to RAM
//   ram_mfc/ram_dout             asynchronous completion and read data from RAM
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_data,
    input  logic        d_req,
    input  logic [5:0]  d_opcode,
    input  logic [7:0]  d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [63:0] d_rdata,
    output logic        ram_mfa,
    input  logic        ram_mfc,
    output logic [5:0]  ram_opcode,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [5:0] OP_LD = 6'b001000;
    localparam logic [5:0] OP_ST = 6'b000100;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic        grant_q, grant_d;          // 1 = data port owns the transaction
    logic        last_grant_q, last_grant_d; // 1 = data was granted last
    logic        dbl_q, dbl_d;
    logic        second_q, second_d;        // second word of a double in progress
    logic        load_q, load_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mfa_q, mfa_d;
    logic [5:0]  opc_q, opc_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] rd_hi_q, rd_hi_d;
    logic [31:0] rd_lo_q, rd_lo_d;
    logic        if_ack_q, if_ack_d;
    logic        if_err_q, if_err_d;
    logic [31:0] if_data_q, if_data_d;
    logic        d_ack_q, d_ack_d;
    logic        d_err_q, d_err_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        sync1_q, mfc_s_q;

    // Opcode decode: size 0 byte, 1 half, 2 word, 3 double.
    logic       d_legal, d_load, d_misalign, d_dbl;
    logic [1:0] d_size;

    always_comb begin
        d_legal = 1'b1;
        d_load  = 1'b0;
        d_size  = 2'd2;
        case (d_opcode)
            6'b001001, 6'b000001: begin d_load = 1'b1; d_size = 2'd0; end
            6'b001010, 6'b000010: begin d_load = 1'b1; d_size = 2'd1; end
            6'b001000:            begin d_load = 1'b1; d_size = 2'd2; end
            6'b000011:            begin d_load = 1'b1; d_size = 2'd3; end
            6'b000101:            d_size = 2'd0;
            6'b000110:            d_size = 2'd1;
            6'b000100:            d_size = 2'd2;
            6'b000111:            d_size = 2'd3;
            default:              d_legal = 1'b0;
        endcase
        case (d_size)
            2'd0:    d_misalign = 1'b0;
            2'd1:    d_misalign = d_addr[0];
            2'd2:    d_misalign = |d_addr[1:0];
            default: d_misalign = |d_addr[2:0];
        endcase
        d_dbl = (d_size == 2'd3);
    end

    // Data wins when alone, or when both request and fetch was served last.
    logic pick_data;
    assign pick_data = d_req & (~if_req | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        dbl_d        = dbl_q;
        second_d     = second_q;
        load_d       = load_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        mfa_d        = mfa_q;
        opc_d        = opc_q;
        addr_d       = addr_q;
        din_d        = din_q;
        rd_hi_d      = rd_hi_q;
        rd_lo_d      = rd_lo_q;
        if_data_d    = if_data_q;
        d_rdata_d    = d_rdata_q;
        if_ack_d     = 1'b0;
        if_err_d     = 1'b0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_d      = pick_data;
                    last_grant_d = pick_data;
                    cnt_d        = 8'd0;
                    err_d        = 1'b0;
                    second_d     = 1'b0;
                    if (pick_data) begin
                        if (!d_legal || d_misalign) begin
                            state_d = DONE;
                            d_ack_d = 1'b1;
                            d_err_d = 1'b1;
                        end else begin
                            state_d = ACCESS;
                            mfa_d   = 1'b1;
                            dbl_d   = d_dbl;
                            load_d  = d_load;
                            addr_d  = d_addr;
                            if (d_dbl) begin
                                opc_d = d_load ? OP_LD : OP_ST;
                                din_d = d_wdata[63:32];
                            end else begin
                                opc_d = d_opcode;
                                din_d = d_wdata[31:0];
                            end
                        end
                    end else begin
                        if (|if_addr[1:0]) begin
                            state_d  = DONE;
                            if_ack_d = 1'b1;
                            if_err_d = 1'b1;
                        end else begin
                            state_d = ACCESS;
                            mfa_d   = 1'b1;
                            dbl_d   = 1'b0;
                            load_d  = 1'b1;
                            opc_d   = OP_LD;
                            addr_d  = if_addr;
                        end
                    end
                end
            end

            ACCESS: begin
                if (mfc_s_q) begin
                    state_d = RELEASE;
                    mfa_d   = 1'b0;
                    if (dbl_q && !second_q) begin
                        rd_hi_d = ram_dout;
                    end else begin
                        rd_lo_d = ram_dout;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASE;
                    mfa_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RELEASE: begin
                if (!mfc_s_q) begin
                    if (dbl_q && !second_q && !err_q) begin
                        state_d  = ACCESS;
                        mfa_d    = 1'b1;
                        cnt_d    = 8'd0;
                        second_d = 1'b1;
                        addr_d   = addr_q + 8'd4;
                        din_d    = d_wdata[31:0];
                    end else begin
                        state_d = DONE;
                        if (grant_q) begin
                            d_ack_d = 1'b1;
                            d_err_d = err_q;
                            if (load_q) begin
                                d_rdata_d = dbl_q ? {rd_hi_q, rd_lo_q} : {32'b0, rd_lo_q};
                            end
                        end else begin
                            if_ack_d  = 1'b1;
                            if_err_d  = err_q;
                            if_data_d = rd_lo_q;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            dbl_q        <= 1'b0;
            second_q     <= 1'b0;
            load_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 8'd0;
            mfa_q        <= 1'b0;
            opc_q        <= 6'd0;
            addr_q       <= 8'd0;
            din_q        <= 32'd0;
            rd_hi_q      <= 32'd0;
            rd_lo_q      <= 32'd0;
            if_ack_q     <= 1'b0;
            if_err_q     <= 1'b0;
            if_data_q    <= 32'd0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= 64'd0;
            sync1_q      <= 1'b0;
            mfc_s_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            dbl_q        <= dbl_d;
            second_q     <= second_d;
            load_q       <= load_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            mfa_q        <= mfa_d;
            opc_q        <= opc_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            rd_hi_q      <= rd_hi_d;
            rd_lo_q      <= rd_lo_d;
            if_ack_q     <= if_ack_d;
            if_err_q     <= if_err_d;
            if_data_q    <= if_data_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
            sync1_q      <= ram_mfc;
            mfc_s_q      <= sync1_q;
        end
    end

    assign if_ack     = if_ack_q;
    assign if_err     = if_err_q;
    assign if_data    = if_data_q;
    assign d_ack      = d_ack_q;
    assign d_err      = d_err_q;
    assign d_rdata    = d_rdata_q;
    assign ram_mfa    = mfa_q;
    assign ram_opcode = opc_q;
    assign ram_addr   = addr_q;
    assign ram_din    = din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a zero-delay word RAM model.
module tb_mem_access_ctrl;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ack;
    logic        if_err;
    logic [31:0] if_data;
    logic        d_req;
    logic [5:0]  d_opcode;
    logic [7:0]  d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [63:0] d_rdata;
    logic        ram_mfa;
    logic        ram_mfc;
    logic [5:0]  ram_opcode;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        ram_resp;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_err     (if_err),
        .if_data    (if_data),
        .d_req      (d_req),
        .d_opcode   (d_opcode),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_err      (d_err),
        .d_rdata    (d_rdata),
        .ram_mfa    (ram_mfa),
        .ram_mfc    (ram_mfc),
        .ram_opcode (ram_opcode),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // Zero-delay RAM: MFC follows MFA unless ram_resp is held low; only word stores modelled.
    logic [31:0] mem [0:63];
    assign ram_mfc  = ram_mfa & ram_resp;
    assign ram_dout = mem[ram_addr[7:2]];
    always @(posedge clk) begin
        if (ram_mfa && ram_opcode == 6'b000100) mem[ram_addr[7:2]] <= ram_din;
    end

    // Free-running monitors; the stimulus reads differences across an operation.
    logic       mfa_prev  = 1'b0;
    logic       both_ack  = 1'b0;
    int         mfa_cyc   = 0;
    int         n_txn     = 0;
    int         d_ack_cnt = 0;
    logic [7:0] txn_addr [0:15];
    always @(negedge clk) begin
        if (ram_mfa) mfa_cyc <= mfa_cyc + 1;
        if (ram_mfa && !mfa_prev) begin
            txn_addr[n_txn[3:0]] <= ram_addr;
            n_txn <= n_txn + 1;
        end
        mfa_prev <= ram_mfa;
        if (d_ack) d_ack_cnt <= d_ack_cnt + 1;
        if (if_ack && d_ack) both_ack <= 1'b1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns edges until d_ack.
    task automatic run_data(input logic [5:0] op, input logic [7:0] addr, input logic [63:0] wd,
                            output int lat, output logic err, output logic [63:0] rd);
        d_opcode = op;
        d_addr   = addr;
        d_wdata  = wd;
        d_req    = 1'b1;
        lat      = 0;
        while (!d_ack && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        err   = d_err;
        rd    = d_rdata;
        d_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_fetch(input logic [7:0] addr, output int lat, output logic err,
                             output logic [31:0] rd);
        if_addr = addr;
        if_req  = 1'b1;
        lat     = 0;
        while (!if_ack && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        err    = if_err;
        rd     = if_data;
        if_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Both ports request together; returns the edge of each port's ack.
    task automatic arb_round(output int dt, output int ft);
        if_addr  = 8'h24;
        d_opcode = 6'b001000;
        d_addr   = 8'h10;
        d_req    = 1'b1;
        if_req   = 1'b1;
        dt = 0;
        ft = 0;
        for (int e = 1; e <= 40 && (dt == 0 || ft == 0); e++) begin
            @(posedge clk);
            #1;
            if (d_ack && dt == 0) begin dt = e; d_req = 1'b0; end
            if (if_ack && ft == 0) begin ft = e; if_req = 1'b0; end
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  bad_op   [0:2];
    logic [7:0]  bad_addr [0:2];

    initial begin
        int          lat, dt, ft, base, m0, a0;
        logic        e;
        logic [63:0] rd;
        logic [31:0] fd;

        bad_op[0] = 6'b000011; bad_addr[0] = 8'h04;
        bad_op[1] = 6'b000010; bad_addr[1] = 8'h03;
        bad_op[2] = 6'b111111; bad_addr[2] = 8'h00;

        reset = 1'b1; if_req = 1'b0; if_addr = 8'h0; d_req = 1'b0;
        d_opcode = 6'h0; d_addr = 8'h0; d_wdata = 64'h0; ram_resp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_acks", {60'b0, if_ack, if_err, d_ack, d_err}, 64'h0);
        check_eq("rst_ram", {ram_mfa, ram_opcode, ram_addr, ram_din}, 64'h0);
        check_eq("rst_data", d_rdata | {32'b0, if_data}, 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single store then load.
        run_data(6'b000100, 8'h10, 64'h0000_0000_DEAD_BEEF, lat, e, rd);
        check_eq("st_lat", 64'(lat), 64'd7);
        check_eq("st_err", 64'(e), 64'd0);
        run_data(6'b001000, 8'h10, 64'h0, lat, e, rd);
        check_eq("ld_lat", 64'(lat), 64'd7);
        check_eq("ld_err", 64'(e), 64'd0);
        check_eq("ld_data", rd, 64'h0000_0000_DEAD_BEEF);

        // Double store then double load.
        base = n_txn;
        run_data(6'b000111, 8'h20, 64'h1122_3344_5566_7788, lat, e, rd);
        check_eq("std_lat", 64'(lat), 64'd13);
        check_eq("std_err", 64'(e), 64'd0);
        check_eq("std_ntxn", 64'(n_txn - base), 64'd2);
        check_eq("std_addr0", 64'(txn_addr[base[3:0]]), 64'h20);
        a0 = base + 1;
        check_eq("std_addr1", 64'(txn_addr[a0[3:0]]), 64'h24);
        run_data(6'b000011, 8'h20, 64'h0, lat, e, rd);
        check_eq("ldd_lat", 64'(lat), 64'd13);
        check_eq("ldd_data", rd, 64'h1122_3344_5566_7788);

        // Rejected requests: ack one edge later, no RAM access.
        for (int i = 0; i < 3; i++) begin
            m0 = mfa_cyc;
            run_data(bad_op[i], bad_addr[i], 64'h0, lat, e, rd);
            check_eq("bad_lat", 64'(lat), 64'd1);
            check_eq("bad_err", 64'(e), 64'd1);
            check_eq("bad_nomfa", 64'(mfa_cyc - m0), 64'd0);
        end

        // Fetch, aligned and misaligned.
        run_fetch(8'h20, lat, e, fd);
        check_eq("if_lat", 64'(lat), 64'd7);
        check_eq("if_err", 64'(e), 64'd0);
        check_eq("if_data", 64'(fd), 64'h1122_3344);
        run_fetch(8'h21, lat, e, fd);
        check_eq("if_bad_lat", 64'(lat), 64'd1);
        check_eq("if_bad_err", 64'(e), 64'd1);

        // Arbitration from reset: data, fetch, data, fetch.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            arb_round(dt, ft);
            check_eq("arb_d_first", 64'(dt), 64'd7);
            check_eq("arb_if_second", 64'(ft), 64'd15);
            check_eq("arb_d_data", d_rdata, 64'h0000_0000_DEAD_BEEF);
            check_eq("arb_if_data", 64'(if_data), 64'h5566_7788);
        end

        // MFC never rises: timeout after TIMEOUT cycles of MFA.
        ram_resp = 1'b0;
        m0 = mfa_cyc;
        run_data(6'b001000, 8'h10, 64'h0, lat, e, rd);
        check_eq("to_lat", 64'(lat), 64'(TIMEOUT + 2));
        check_eq("to_err", 64'(e), 64'd1);
        check_eq("to_mfa_cyc", 64'(mfa_cyc - m0), 64'(TIMEOUT));
        base = n_txn;
        m0   = mfa_cyc;
        run_data(6'b000011, 8'h20, 64'h0, lat, e, rd);
        check_eq("to_ldd_lat", 64'(lat), 64'(TIMEOUT + 2));
        check_eq("to_ldd_err", 64'(e), 64'd1);
        check_eq("to_ldd_ntxn", 64'(n_txn - base), 64'd1);
        check_eq("to_ldd_mfa", 64'(mfa_cyc - m0), 64'(TIMEOUT));
        ram_resp = 1'b1;

        // Reset in the middle of an std access.
        base     = d_ack_cnt;
        d_opcode = 6'b000111;
        d_addr   = 8'h28;
        d_wdata  = 64'hAAAA_BBBB_CCCC_DDDD;
        d_req    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_in_access", 64'(ram_mfa), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("abort_ram", {ram_mfa, ram_opcode, ram_addr, ram_din}, 64'h0);
        check_eq("abort_outs", d_rdata | {32'b0, if_data} | {60'b0, if_ack, if_err, d_ack, d_err},
                 64'h0);
        d_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("abort_no_ack", 64'(d_ack_cnt - base), 64'd0);
        run_fetch(8'h10, lat, e, fd);
        check_eq("post_if_lat", 64'(lat), 64'd7);
        check_eq("post_if_err", 64'(e), 64'd0);
        check_eq("post_if_data", 64'(fd), 64'hDEAD_BEEF);

        check_eq("acks_exclusive", 64'(both_ack), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
